key_schedule192_rev: RTL and testbench

//  Sequential AES-192 round-key provider for the inverse cipher. It expands a 192-bit

---
 rtl/key_schedule192_rev_if.sv | 28 ++
 rtl/key_schedule192_rev.sv | 177 +++++++++++++++++
 tb/tb_key_schedule192_rev.sv | 285 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/key_schedule192_rev_if.sv
// Round-key stream bundle for key_schedule192_rev.
//   key_in    192-bit cipher key (word0 in [191:160])
//   key_load  1-cycle request to latch key_in and start expansion
//   busy      provider is expanding or serving
//   rk_valid / rk_ready / rk_data / rk_round / rk_last  round-key stream, rounds 12..0
//   done      1-cycle pulse after the round-0 key is accepted
// master: the controller/consumer side; slave: the key-schedule provider.
interface key_schedule192_rev_if;
  logic [191:0] key_in;
  logic         key_load;
  logic         busy;
  logic         rk_valid;
  logic         rk_ready;
  logic [127:0] rk_data;
  logic [3:0]   rk_round;
  logic         rk_last;
  logic         done;

  modport master (
    output key_in, key_load, rk_ready,
    input  busy, rk_valid, rk_data, rk_round, rk_last, done
  );

  modport slave (
    input  key_in, key_load, rk_ready,
    output busy, rk_valid, rk_data, rk_round, rk_last, done
  );
endinterface

// File: rtl/key_schedule192_rev.sv
// AES-192 round-key provider for the inverse cipher.
// Expands the cipher key into 52 words (one word per cycle, one shared SubWord),
// then streams the 13 round keys from round 12 down to round 0.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    key_schedule192_rev_if.slave (key load, round-key stream, busy/done)
//
// state  | meaning
// IDLE   | waiting for key_load
// EXPAND | producing w[6..51], one word per cycle (46 cycles)
// SERVE  | presenting round keys r = 12..0 on the valid/ready stream
module key_schedule192_rev (
  input  logic                  clk,
  input  logic                  rst_n,
  key_schedule192_rev_if.slave  bus
);
  localparam int NK = 6;
  localparam int NR = 12;
  localparam int NB = 4;
  localparam int NW = NB * (NR + 1);
  localparam logic [5:0] LAST_IDX  = 6'(NW - 1);
  localparam logic [3:0] TOP_ROUND = 4'(NR);

  // Forward S-box, entry 0 in the top byte.
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] x);
    // entry x sits at bit offset 8*(255-x) = {~x, 3'b000}
    return SBOX[{~x, 3'b000} +: 8];
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] a);
    return {sbox(a[31:24]), sbox(a[23:16]), sbox(a[15:8]), sbox(a[7:0])};
  endfunction

  typedef enum logic [1:0] {IDLE, EXPAND, SERVE} state_t;

  state_t        state;
  logic [31:0]   w   [NW];
  // Sliding window of the last six words, w[i-6..i-1], so expansion never
  // needs a random read of the full array.
  logic [31:0]   win [NK];
  logic [5:0]    idx;
  logic [2:0]    phase;
  logic [7:0]    rcon;
  logic [3:0]    r;
  logic          rk_valid_q;
  logic          rk_last_q;
  logic          done_q;
  logic [127:0]  rk_data_q;

  logic [31:0]   t_word;
  logic [31:0]   new_word;
  logic [3:0]    rd_r;
  logic [127:0]  rd_data;
  logic          load_key;
  logic          take;

  always_comb begin
    t_word = win[NK-1];
    if (phase == 3'd0)
      t_word = sub_word({win[NK-1][23:0], win[NK-1][31:24]}) ^ {rcon, 24'h0};
    new_word = win[0] ^ t_word;
  end

  // key_load is ignored only while expanding; in SERVE it aborts the stream.
  assign load_key = bus.key_load && (state != EXPAND);
  assign take     = rk_valid_q && bus.rk_ready;

  // Round key read port: the current round when priming, the next one on a
  // transfer, so the following key is registered with no bubble.
  always_comb begin
    rd_r = r;
    if (rk_valid_q && r != 4'd0)
      rd_r = r - 4'd1;
    rd_data = {w[{rd_r, 2'd0}], w[{rd_r, 2'd1}], w[{rd_r, 2'd2}], w[{rd_r, 2'd3}]};
  end

  // Word storage carries no reset; only the control path does.
  always_ff @(posedge clk) begin
    if (load_key) begin
      for (int k = 0; k < NK; k++)
        w[k] <= bus.key_in[32*(NK-1-k) +: 32];
    end else if (state == EXPAND) begin
      w[idx] <= new_word;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      idx        <= 6'd0;
      phase      <= 3'd0;
      rcon       <= 8'h00;
      r          <= 4'd0;
      rk_valid_q <= 1'b0;
      rk_last_q  <= 1'b0;
      done_q     <= 1'b0;
      rk_data_q  <= '0;
      for (int k = 0; k < NK; k++)
        win[k] <= '0;
    end else begin
      done_q <= 1'b0;
      if (load_key) begin
        for (int k = 0; k < NK; k++)
          win[k] <= bus.key_in[32*(NK-1-k) +: 32];
        idx        <= 6'(NK);
        phase      <= 3'd0;
        rcon       <= 8'h01;
        rk_valid_q <= 1'b0;
        rk_last_q  <= 1'b0;
        state      <= EXPAND;
      end else begin
        case (state)
          EXPAND: begin
            for (int k = 0; k < NK-1; k++)
              win[k] <= win[k+1];
            win[NK-1] <= new_word;
            idx       <= idx + 6'd1;
            phase     <= (phase == 3'(NK-1)) ? 3'd0 : phase + 3'd1;
            if (phase == 3'd0)
              rcon <= {rcon[6:0], 1'b0};
            if (idx == LAST_IDX) begin
              state <= SERVE;
              r     <= TOP_ROUND;
            end
          end
          SERVE: begin
            // First SERVE cycle registers round 12 once w[51] is in the array.
            if (!rk_valid_q) begin
              rk_valid_q <= 1'b1;
              rk_data_q  <= rd_data;
              rk_last_q  <= (r == 4'd0);
            end else if (take) begin
              if (r == 4'd0) begin
                state      <= IDLE;
                rk_valid_q <= 1'b0;
                rk_last_q  <= 1'b0;
                done_q     <= 1'b1;
              end else begin
                r         <= rd_r;
                rk_data_q <= rd_data;
                rk_last_q <= (rd_r == 4'd0);
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.busy     = (state != IDLE);
  assign bus.rk_valid = rk_valid_q;
  assign bus.rk_data  = rk_data_q;
  assign bus.rk_round = r;
  assign bus.rk_last  = rk_last_q;
  assign bus.done     = done_q;
endmodule

// File: tb/tb_key_schedule192_rev.sv
// Testbench for key_schedule192_rev: directed FIPS-197 vectors in a table,
// a behavioural key-expansion model, and hand sequences for stall, abort and reset.
module tb_key_schedule192_rev;
  localparam logic [191:0] KEY_A2   = 192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b;
  localparam logic [191:0] KEY_ZERO = 192'h0;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  key_schedule192_rev_if bus ();
  key_schedule192_rev dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int n_checks = 0;
  int n_pass   = 0;
  int n_stall  = 0;

  typedef struct {
    logic [191:0] key;
    logic [3:0]   round;
    logic [127:0] exp;
  } vec_t;
  vec_t vecs[7];

  logic [7:0]   sb [256];
  logic [31:0]  mw [52];
  logic [127:0] got_data  [13];
  logic [3:0]   got_round [13];
  logic         got_last  [13];
  int           got_n;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = 8'h00; x = a; y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
      y = y >> 1;
    end
    return p;
  endfunction

  // S-box derived from GF(2^8) inverse plus affine map, independent of any table.
  task automatic build_sbox();
    logic [7:0] inv, b;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      b = inv;
      sb[x] = b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
    end
  endtask

  task automatic model_expand(input logic [191:0] k);
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 6; i++) mw[i] = k[191-32*i -: 32];
    for (int i = 6; i < 52; i++) begin
      t = mw[i-1];
      if (i % 6 == 0) begin
        t = {sb[t[23:16]], sb[t[15:8]], sb[t[7:0]], sb[t[31:24]]} ^ {rc, 24'h0};
        rc = rc << 1;
      end
      mw[i] = mw[i-6] ^ t;
    end
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, "_busy"},     128'(bus.busy),     128'(0));
    check({name, "_rk_valid"}, 128'(bus.rk_valid), 128'(0));
    check({name, "_rk_last"},  128'(bus.rk_last),  128'(0));
    check({name, "_done"},     128'(bus.done),     128'(0));
    check({name, "_rk_data"},  bus.rk_data,        128'(0));
    check({name, "_rk_round"}, 128'(bus.rk_round), 128'(0));
  endtask

  task automatic do_load(input logic [191:0] k);
    @(negedge clk);
    bus.key_in   = k;
    bus.key_load = 1'b1;
    @(negedge clk);
    bus.key_load = 1'b0;
  endtask

  // Returns edges after the load edge until rk_valid is seen (100 = timed out).
  task automatic wait_valid(input int pulse_at, input logic [191:0] alt, output int cyc);
    cyc = 0;
    while (!bus.rk_valid && cyc < 100) begin
      if (cyc == pulse_at) begin
        bus.key_in   = alt;
        bus.key_load = 1'b1;
      end
      @(negedge clk);
      bus.key_load = 1'b0;
      cyc++;
    end
  endtask

  task automatic collect(input bit rand_ready, input int abort_round, output int cycles);
    bit stalled, rdy, last_xfer;
    logic [127:0] pd;
    logic [3:0]   pr;
    got_n = 0; cycles = 0; stalled = 0; pd = '0; pr = '0;
    for (int j = 0; j < 13; j++) begin
      got_data[j] = '0; got_round[j] = 4'hf; got_last[j] = 1'bx;
    end
    while (cycles < 300) begin
      if (stalled) begin
        n_stall++;
        check("stall_data",  bus.rk_data,        pd);
        check("stall_round", 128'(bus.rk_round), 128'(pr));
      end
      if (abort_round >= 0 && bus.rk_valid && int'(bus.rk_round) == abort_round) break;
      rdy = rand_ready ? ($urandom_range(0, 2) != 0) : 1'b1;
      bus.rk_ready = rdy;
      last_xfer = bus.rk_valid && rdy && bus.rk_round == 4'd0;
      if (bus.rk_valid && rdy) begin
        if (got_n < 13) begin
          got_data[got_n]  = bus.rk_data;
          got_round[got_n] = bus.rk_round;
          got_last[got_n]  = bus.rk_last;
        end
        got_n++;
      end
      stalled = bus.rk_valid && !rdy;
      pd = bus.rk_data;
      pr = bus.rk_round;
      @(negedge clk);
      cycles++;
      if (last_xfer) break;
    end
  endtask

  // Called at the negedge right after the round-0 transfer edge.
  task automatic end_of_stream(input string name);
    check({name, "_valid_drop"}, 128'(bus.rk_valid), 128'(0));
    check({name, "_done_pulse"}, 128'(bus.done),     128'(1));
    check({name, "_busy_idle"},  128'(bus.busy),     128'(0));
    @(negedge clk);
    check({name, "_done_once"},  128'(bus.done),     128'(0));
  endtask

  task automatic verify_stream(input string name, input logic [191:0] key);
    check({name, "_xfer_count"}, 128'(got_n), 128'(13));
    for (int j = 0; j < 13; j++) begin
      check($sformatf("%s_order%0d", name, j), 128'(got_round[j]), 128'(12 - j));
      check($sformatf("%s_data%0d", name, j), got_data[j],
            {mw[4*(12-j)], mw[4*(12-j)+1], mw[4*(12-j)+2], mw[4*(12-j)+3]});
      check($sformatf("%s_last%0d", name, j), 128'(got_last[j]), 128'(j == 12));
    end
    for (int v = 0; v < 7; v++)
      if (vecs[v].key == key)
        check($sformatf("%s_vec_r%0d", name, vecs[v].round),
              got_data[12 - int'(vecs[v].round)], vecs[v].exp);
  endtask

  task automatic idle_watch(input string name);
    bit seen;
    seen = 0;
    repeat (60) begin
      @(negedge clk);
      if (bus.rk_valid || bus.busy || bus.done) seen = 1;
    end
    check(name, 128'(seen), 128'(0));
  endtask

  initial begin
    int cyc;
    // Hand-computed FIPS-197 A.2 words; zero key gives w4,w5 = 0 so round 1 starts with zeros.
    vecs[0] = '{KEY_A2,   4'd12, 128'he98ba06f448c773c8ecc720401002202};
    vecs[1] = '{KEY_A2,   4'd3,  128'h4db7b4bd69b5411885a74796e92538fd};
    vecs[2] = '{KEY_A2,   4'd2,  128'hec12068e6c827f6b0e7a95b95c56fec2};
    vecs[3] = '{KEY_A2,   4'd1,  128'h62f8ead2522c6b7bfe0c91f72402f5a5};
    vecs[4] = '{KEY_A2,   4'd0,  128'h8e73b0f7da0e6452c810f32b809079e5};
    vecs[5] = '{KEY_ZERO, 4'd1,  128'h00000000000000006263636362636363};
    vecs[6] = '{KEY_ZERO, 4'd2,  128'h62636363626363636263636362636363};

    bus.key_in = '0; bus.key_load = 1'b0; bus.rk_ready = 1'b0;
    build_sbox();
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // A.2 key, always ready
    model_expand(KEY_A2);
    bus.rk_ready = 1'b1;
    do_load(KEY_A2);
    check("busy_expand", 128'(bus.busy), 128'(1));
    wait_valid(-1, KEY_ZERO, cyc);
    check("latency_a2", 128'(cyc), 128'(47));
    collect(1'b0, -1, cyc);
    check("consecutive_a2", 128'(cyc), 128'(13));
    end_of_stream("a2");
    verify_stream("a2", KEY_A2);
    check("w6",  128'(dut.w[6]),  128'(32'hfe0c91f7));
    check("w12", 128'(dut.w[12]), 128'(32'h4db7b4bd));

    // A.2 key with random backpressure
    bus.rk_ready = 1'b0;
    n_stall = 0;
    do_load(KEY_A2);
    wait_valid(-1, KEY_ZERO, cyc);
    check("latency_stall", 128'(cyc), 128'(47));
    collect(1'b1, -1, cyc);
    end_of_stream("stall");
    verify_stream("stall", KEY_A2);
    check("stalls_seen", 128'(n_stall > 0), 128'(1));

    // all-zero key
    model_expand(KEY_ZERO);
    bus.rk_ready = 1'b1;
    do_load(KEY_ZERO);
    wait_valid(-1, KEY_ZERO, cyc);
    collect(1'b0, -1, cyc);
    end_of_stream("zero");
    verify_stream("zero", KEY_ZERO);

    // key_load during EXPAND is ignored
    model_expand(KEY_A2);
    do_load(KEY_A2);
    wait_valid(20, KEY_ZERO, cyc);
    check("latency_ignore", 128'(cyc), 128'(47));
    collect(1'b0, -1, cyc);
    end_of_stream("ignore");
    verify_stream("ignore", KEY_A2);

    // key_load during SERVE at r=7 aborts and restarts with the new key
    do_load(KEY_A2);
    wait_valid(-1, KEY_ZERO, cyc);
    collect(1'b0, 7, cyc);
    check("abort_prior_xfers", 128'(got_n), 128'(5));
    bus.key_in   = KEY_ZERO;
    bus.key_load = 1'b1;
    @(negedge clk);
    bus.key_load = 1'b0;
    check("abort_valid_drop", 128'(bus.rk_valid), 128'(0));
    check("abort_busy",       128'(bus.busy),     128'(1));
    model_expand(KEY_ZERO);
    wait_valid(-1, KEY_ZERO, cyc);
    check("abort_latency", 128'(cyc), 128'(47));
    collect(1'b0, -1, cyc);
    end_of_stream("abort");
    verify_stream("abort", KEY_ZERO);

    // asynchronous reset mid-EXPAND
    do_load(KEY_A2);
    repeat (10) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("rst_expand");
    @(negedge clk);
    rst_n = 1'b1;
    idle_watch("idle_after_rst_expand");

    // asynchronous reset mid-SERVE
    do_load(KEY_A2);
    wait_valid(-1, KEY_ZERO, cyc);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("rst_serve");
    @(negedge clk);
    rst_n = 1'b1;
    idle_watch("idle_after_rst_serve");

    // normal operation after reset
    model_expand(KEY_A2);
    do_load(KEY_A2);
    wait_valid(-1, KEY_ZERO, cyc);
    check("latency_post_rst", 128'(cyc), 128'(47));
    collect(1'b0, -1, cyc);
    end_of_stream("post_rst");
    verify_stream("post_rst", KEY_A2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
